// File: rtl/mult_pkg.sv
// Shared state encodings and default widths for the product accumulator.
package mult_pkg;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam int P_WID_D   = 64;
  localparam int ACC_WID_D = 72;
  localparam int CNT_WID_D = 8;
endpackage

// File: rtl/cla_adder.sv
// N-bit adder built from 4-bit carry-lookahead groups; group carries ripple.
module cla_adder #(
  parameter int N = 72
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);
  localparam int GRP = 4;

  logic [N-1:0] g, p;
  logic [N:0]   c;
  logic         gg, pp;

  assign g = a & b;
  assign p = a ^ b;

  // Each bit's carry is expanded back to the start of its group, so only the
  // group-entry carry travels serially.
  always_comb begin
    c    = '0;
    gg   = 1'b0;
    pp   = 1'b0;
    c[0] = cin;
    for (int i = 0; i < N; i++) begin
      gg = g[i];
      pp = p[i];
      for (int j = i - 1; j >= i - (i % GRP); j--) begin
        gg = gg | (pp & g[j]);
        pp = pp & p[j];
      end
      c[i+1] = gg | (pp & c[i - (i % GRP)]);
    end
  end

  assign s    = p ^ c[N-1:0];
  assign cout = c[N];
endmodule

// File: rtl/mult_accumulator.sv
// Sums a burst of unsigned products into a wide accumulator with term count and
// sticky overflow. Define MULT_ACC_SAT_EN to clamp the sum at all-ones on overflow.
module mult_accumulator
  import mult_pkg::*;
#(
  parameter int P_WID   = P_WID_D,
  parameter int ACC_WID = ACC_WID_D,
  parameter int CNT_WID = CNT_WID_D
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [P_WID-1:0]   product,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_WID-1:0] acc_out,
  output logic [CNT_WID-1:0] term_cnt,
  output logic               overflow
);
  state_t               state, state_nx;
  logic                 accept, drain, cout;
  logic [ACC_WID-1:0]   sum, acc_nx;
  logic [CNT_WID-1:0]   cnt_nx;
  logic                 ovf_nx;

  assign in_ready  = !rst && (state != S_HOLD) && !clear;
  assign accept    = in_valid && in_ready;
  assign drain     = (state == S_HOLD) && out_ready;
  assign out_valid = (state == S_HOLD);

  cla_adder #(.N(ACC_WID)) u_add (
    .a    (acc_out),
    .b    (ACC_WID'(product)),
    .cin  (1'b0),
    .s    (sum),
    .cout (cout)
  );

  always_comb begin
    state_nx = state;
    acc_nx   = acc_out;
    cnt_nx   = term_cnt;
    ovf_nx   = overflow;
    // clear outranks both the result handshake and a new term
    if (clear || drain) begin
      state_nx = S_IDLE;
      acc_nx   = '0;
      cnt_nx   = '0;
      ovf_nx   = 1'b0;
    end else if (accept) begin
      state_nx = in_last ? S_HOLD : S_ACCUM;
      ovf_nx   = overflow | cout;
`ifdef MULT_ACC_SAT_EN
      acc_nx   = (overflow || cout) ? '1 : sum;
`else
      acc_nx   = sum;
`endif
      if (term_cnt != '1) cnt_nx = term_cnt + CNT_WID'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      acc_out  <= '0;
      term_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nx;
      acc_out  <= acc_nx;
      term_cnt <= cnt_nx;
      overflow <= ovf_nx;
    end
  end
endmodule

// File: tb/tb_mult_accumulator.sv
// Bench: directed vector table, hand sequences and random bursts against an exact-sum model.
module tb_mult_accumulator;
  localparam int P = 64, A = 72, AO = 64, C = 8;

  logic clk = 1'b0, rst = 1'b1, clear = 1'b0, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [P-1:0] product = '0;
  logic in_ready, out_valid, overflow, ov_in_ready, ov_out_valid, ov_overflow;
  logic [A-1:0]  acc_out;
  logic [AO-1:0] ov_acc_out;
  logic [C-1:0]  term_cnt, ov_term_cnt;

  always #5 clk = ~clk;

  mult_accumulator #(.P_WID(P), .ACC_WID(A), .CNT_WID(C)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .product(product), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .acc_out(acc_out), .term_cnt(term_cnt), .overflow(overflow));

  mult_accumulator #(.P_WID(P), .ACC_WID(AO), .CNT_WID(C)) dut_ov (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(ov_in_ready),
    .product(product), .in_last(in_last), .out_valid(ov_out_valid), .out_ready(out_ready),
    .acc_out(ov_acc_out), .term_cnt(ov_term_cnt), .overflow(ov_overflow));

  int nvec = 0, nerr = 0;

  // reference: exact burst sum, term count, result-presented flag
  logic [127:0] m_sum = '0;
  int           m_n = 0;
  bit           m_hold = 1'b0;

  typedef struct {
    bit v, l, orr, clr;
    logic [P-1:0] p;
    bit e_ir, e_vld;
    logic [A-1:0] e_acc;
    logic [C-1:0] e_cnt;
    bit e_ovf;
  } vec_t;
  vec_t tv[$];

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [127:0] exp_acc(input int w);
    logic [127:0] lim;
    lim = 128'd1 << w;
`ifdef MULT_ACC_SAT_EN
    if (m_sum >= lim) return lim - 128'd1;
`endif
    return m_sum & (lim - 128'd1);
  endfunction

  function automatic logic [127:0] exp_ovf(input int w);
    return 128'(m_sum >= (128'd1 << w));
  endfunction

  function automatic logic [127:0] exp_cnt();
    return (m_n > 255) ? 128'd255 : 128'(m_n);
  endfunction

  task automatic mreset();
    m_sum = '0; m_n = 0; m_hold = 1'b0;
  endtask

  task automatic check_all();
    chk("out_valid",   128'(out_valid),    128'(m_hold));
    chk("acc_out",     128'(acc_out),      exp_acc(A));
    chk("term_cnt",    128'(term_cnt),     exp_cnt());
    chk("overflow",    128'(overflow),     exp_ovf(A));
    chk("ov_out_valid",128'(ov_out_valid), 128'(m_hold));
    chk("ov_acc_out",  128'(ov_acc_out),   exp_acc(AO));
    chk("ov_term_cnt", 128'(ov_term_cnt),  exp_cnt());
    chk("ov_overflow", 128'(ov_overflow),  exp_ovf(AO));
  endtask

  // Entered just after a rising edge; drives one cycle, checks, returns after next edge.
  task automatic tick(input bit v, input logic [P-1:0] p, input bit l, input bit orr,
                      input bit clr, output bit ir);
    bit take;
    in_valid = v; product = p; in_last = l; out_ready = orr; clear = clr;
    #1;
    ir = in_ready;
    chk("in_ready",    128'(in_ready),    128'(!m_hold && !clr));
    chk("ov_in_ready", 128'(ov_in_ready), 128'(!m_hold && !clr));
    take = v && !m_hold && !clr;
    @(posedge clk);
    if (clr) mreset();
    else if (m_hold) begin
      if (orr) mreset();
    end else if (take) begin
      m_sum = m_sum + 128'(p);
      m_n++;
      if (l) m_hold = 1'b1;
    end
    #1;
    check_all();
  endtask

  task automatic row(input bit v, input logic [P-1:0] p, input bit l, input bit orr, input bit clr,
                     input bit e_ir, input bit e_vld, input logic [A-1:0] e_acc, input logic [C-1:0] e_cnt);
    tv.push_back('{v:v, l:l, orr:orr, clr:clr, p:p, e_ir:e_ir, e_vld:e_vld,
                   e_acc:e_acc, e_cnt:e_cnt, e_ovf:1'b0});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", nvec);
    $fatal(1);
  end

  initial begin
    bit ir;
    logic [P-1:0] ones;
    logic [127:0] sat_or_wrap;
    ones = '1;

    // burst of 3 then held result with in_valid high, then drain
    row(1, 64'd6,   0, 0, 0, 1, 0, 72'd6,   8'd1);
    row(1, 64'd15,  0, 0, 0, 1, 0, 72'd21,  8'd2);
    row(1, 64'd100, 1, 0, 0, 1, 1, 72'd121, 8'd3);
    for (int k = 0; k < 5; k++) row(1, 64'd9, 0, 0, 0, 0, 1, 72'd121, 8'd3);
    row(0, 64'd0,   0, 1, 0, 0, 0, 72'd0,   8'd0);
    row(0, 64'd0,   0, 0, 0, 1, 0, 72'd0,   8'd0);
    // clear with in_valid while accumulating
    row(1, 64'd50,  0, 0, 0, 1, 0, 72'd50,  8'd1);
    row(1, 64'd7,   0, 0, 1, 0, 0, 72'd0,   8'd0);
    row(0, 64'd0,   0, 0, 0, 1, 0, 72'd0,   8'd0);
    // single-term burst
    row(1, 64'd42,  1, 0, 0, 1, 1, 72'd42,  8'd1);
    row(0, 64'd0,   0, 1, 0, 0, 0, 72'd0,   8'd0);
    // clear beats the output handshake in HOLD
    row(1, 64'd5,   1, 0, 0, 1, 1, 72'd5,   8'd1);
    row(0, 64'd0,   0, 1, 1, 0, 0, 72'd0,   8'd0);

    // reset state, checked before any clock edge
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'd0);
    check_all();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < tv.size(); i++) begin
      tick(tv[i].v, tv[i].p, tv[i].l, tv[i].orr, tv[i].clr, ir);
      chk("tbl_in_ready", 128'(ir),        128'(tv[i].e_ir));
      chk("tbl_valid",    128'(out_valid), 128'(tv[i].e_vld));
      chk("tbl_acc",      128'(acc_out),   128'(tv[i].e_acc));
      chk("tbl_cnt",      128'(term_cnt),  128'(tv[i].e_cnt));
      chk("tbl_ovf",      128'(overflow),  128'(tv[i].e_ovf));
    end

    // two all-ones products: 64-bit accumulator overflows, 72-bit one does not
    tick(1, ones, 0, 0, 0, ir);
    tick(1, ones, 1, 0, 0, ir);
`ifdef MULT_ACC_SAT_EN
    sat_or_wrap = {64'd0, 64'hFFFF_FFFF_FFFF_FFFF};
`else
    sat_or_wrap = {64'd0, 64'hFFFF_FFFF_FFFF_FFFE};
`endif
    chk("ovf64_flag", 128'(ov_overflow), 128'd1);
    chk("ovf64_acc",  128'(ov_acc_out),  sat_or_wrap);
    chk("ovf72_acc",  128'(acc_out),     {62'd0, 66'h1_FFFF_FFFF_FFFF_FFFE});
    chk("ovf72_flag", 128'(overflow),    128'd0);
    tick(0, '0, 0, 1, 0, ir);

    // async reset mid-burst: outputs drop without a clock edge
    tick(1, 64'd3, 0, 0, 0, ir);
    tick(1, 64'd4, 0, 0, 0, ir);
    chk("pre_rst_acc", 128'(acc_out), 128'd7);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_acc",    128'(acc_out),   128'd0);
    chk("arst_cnt",    128'(term_cnt),  128'd0);
    chk("arst_valid",  128'(out_valid), 128'd0);
    chk("arst_ready",  128'(in_ready),  128'd0);
    mreset();
    @(posedge clk); #1;
    rst = 1'b0;

    // term counter saturation over 260 terms
    for (int k = 0; k < 259; k++) tick(1, 64'd1, 0, 0, 0, ir);
    tick(1, 64'd1, 1, 0, 0, ir);
    chk("sat_cnt", 128'(term_cnt), 128'd255);
    chk("sat_acc", 128'(acc_out),  128'd260);
    tick(0, '0, 0, 1, 0, ir);

    // random traffic, large products mixed in to exercise 64-bit overflow
    for (int k = 0; k < 400; k++) begin
      logic [P-1:0] rp;
      rp = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) rp = ones;
      else if ($urandom_range(0, 2) == 0) rp = P'($urandom_range(0, 1000));
      tick($urandom_range(0, 3) != 0, rp, $urandom_range(0, 4) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0, ir);
    end
    tick(0, '0, 0, 1, 1, ir);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
